// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared definitions for the multicycle MIPS control FSM.
//   - state_e   : 4-bit FSM state encoding (FETCH = 0), visible on state_o
//   - OP_* / FN_*: instruction opcode and R-type funct field values
//   - ALU_*     : 3-bit ALU operation codes (zero-extended to ALUCW by users)
//   - ALUOP_*   : 2-bit selector from the FSM to the ALU decoder
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12,
    S_JREX    = 4'd13
  } state_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct values
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ALU operations
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // FSM -> ALU decoder selector
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: combinational ALU control decoder.
//   aluop_i      [1:0]      00 add, 01 sub, 10 use funct, 11 treated as funct
//   funct_i      [5:0]      R-type funct field
//   alucontrol_o [ALUCW-1:0] ALU operation, 3-bit code zero-extended
//   bad_funct_o             funct is not one of add/sub/and/or/slt
// bad_funct_o looks at funct alone, independent of aluop_i, so the FSM can
// flag an unsupported R-type instruction while still in DECODE.
module mc_aludec
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCW = 3
) (
  input  logic [1:0]       aluop_i,
  input  logic [5:0]       funct_i,
  output logic [ALUCW-1:0] alucontrol_o,
  output logic             bad_funct_o
);

  logic [2:0] funct_op;
  logic [2:0] alu_op;

  always_comb begin
    funct_op    = ALU_ADD;
    bad_funct_o = 1'b0;
    case (funct_i)
      FN_ADD:  funct_op = ALU_ADD;
      FN_SUB:  funct_op = ALU_SUB;
      FN_AND:  funct_op = ALU_AND;
      FN_OR:   funct_op = ALU_OR;
      FN_SLT:  funct_op = ALU_SLT;
      default: begin
        funct_op    = ALU_ADD;
        bad_funct_o = 1'b1;
      end
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alu_op = ALU_ADD;
      ALUOP_SUB: alu_op = ALU_SUB;
      default:   alu_op = funct_op;
    endcase
  end

  assign alucontrol_o = ALUCW'(alu_op);

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for a multicycle MIPS datapath.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB and stalls in FETCH, MEMRD and
// MEMWR until memready is high.
//   clk, reset (async, active-high)  op, funct: instruction register fields
//   zero: ALU zero flag              memready: memory finishes access now
//   pcen, pcsrc[1:0], iord, memread, memwrite, membyteread, irwrite,
//   regdst, memtoreg, regwrite, alusrca, alusrcb[1:0]: datapath controls
//   alucontrol[ALUCW-1:0]: ALU operation
//   illegal: combinational pulse in DECODE for an unsupported instruction
//   state_o[3:0]: current FSM state
// Handshake: a memory access is requested (memread/memwrite held high) for
// as long as the FSM sits in an access state; it is complete in the cycle
// memready is sampled high, and only that cycle may advance the FSM or
// commit irwrite/pcen.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCW  = 3,
  parameter bit EN_BNE = 1'b1,
  parameter bit EN_JR  = 1'b1,
  parameter bit EN_LBU = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             memready,
  output logic             pcen,
  output logic [1:0]       pcsrc,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             membyteread,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [ALUCW-1:0] alucontrol,
  output logic             illegal,
  output logic [3:0]       state_o
);

  state_e state_q, state_d;

  // Raw (pre-reset-gating) versions of outputs that must be forced low
  // while reset is high.
  logic       pcwrite;
  logic       beq_state;
  logic       bne_state;
  logic       irwrite_raw;
  logic       regwrite_raw;
  logic       memwrite_raw;
  logic       illegal_raw;
  logic [1:0] aluop;
  logic       bad_funct;

  // Decode results, meaningful only while in DECODE.
  state_e     dec_next;
  logic       dec_illegal;

  mc_aludec #(.ALUCW(ALUCW)) u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol),
    .bad_funct_o  (bad_funct)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Instruction decode: choose the execute state, or flag illegal and
  // return to FETCH. jr is checked before bad_funct because 001000 is not
  // an ALU funct; with EN_JR=0 it therefore falls through to illegal.
  always_comb begin
    dec_next    = S_FETCH;
    dec_illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (EN_JR && (funct == FN_JR)) dec_next = S_JREX;
        else if (bad_funct)             dec_illegal = 1'b1;
        else                            dec_next = S_RTYPEEX;
      end
      OP_LW:   dec_next = S_MEMADR;
      OP_LBU: begin
        if (EN_LBU) dec_next = S_MEMADR;
        else        dec_illegal = 1'b1;
      end
      OP_SW:   dec_next = S_MEMADR;
      OP_BEQ:  dec_next = S_BEQEX;
      OP_BNE: begin
        if (EN_BNE) dec_next = S_BNEEX;
        else        dec_illegal = 1'b1;
      end
      OP_ADDI: dec_next = S_ADDIEX;
      OP_J:    dec_next = S_JEX;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (memready) state_d = S_DECODE;
      S_DECODE:  state_d = dec_next;
      // Only lw/lbu/sw reach MEMADR.
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (memready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (memready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_BNEEX:   state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      S_JREX:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore output decode
  always_comb begin
    pcwrite      = 1'b0;
    beq_state    = 1'b0;
    bne_state    = 1'b0;
    pcsrc        = 2'b00;
    iord         = 1'b0;
    memread      = 1'b0;
    memwrite_raw = 1'b0;
    membyteread  = 1'b0;
    irwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    aluop        = ALUOP_ADD;
    illegal_raw  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread     = 1'b1;
        alusrcb     = 2'b01;
        irwrite_raw = memready;
        pcwrite     = memready;
      end
      S_DECODE: begin
        alusrcb     = 2'b11;
        illegal_raw = dec_illegal;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread     = 1'b1;
        iord        = 1'b1;
        membyteread = (op == OP_LBU);
      end
      S_MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      S_MEMWR: begin
        memwrite_raw = 1'b1;
        iord         = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
      end
      S_BEQEX: begin
        alusrca   = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc     = 2'b01;
        beq_state = 1'b1;
      end
      S_BNEEX: begin
        alusrca   = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc     = 2'b01;
        bne_state = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite_raw = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      S_JREX: begin
        pcsrc   = 2'b11;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural writes are suppressed while reset is high so an aborted
  // instruction cannot commit anything, even in the same cycle.
  assign pcen     = ~reset & (pcwrite | (beq_state & zero) | (bne_state & ~zero));
  assign irwrite  = ~reset & irwrite_raw;
  assign regwrite = ~reset & regwrite_raw;
  assign memwrite = ~reset & memwrite_raw;
  assign illegal  = ~reset & illegal_raw;
  assign state_o  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a default instance (all features on,
// ALUCW=3) and a reduced instance (ALUCW=4, bne/jr/lbu disabled), each with
// its own stimulus signals on a shared clock. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
module tb_multicycle_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance signals
  logic       rst, zero, memready;
  logic [5:0] op, funct;
  logic       pcen, iord, memread, memwrite, membyteread, irwrite;
  logic       regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;
  logic [3:0] state_o;

  // reduced instance signals
  logic       v_rst, v_zero, v_memready;
  logic [5:0] v_op, v_funct;
  logic       v_pcen, v_iord, v_memread, v_memwrite, v_membyteread, v_irwrite;
  logic       v_regdst, v_memtoreg, v_regwrite, v_alusrca, v_illegal;
  logic [1:0] v_pcsrc, v_alusrcb;
  logic [3:0] v_alucontrol;
  logic [3:0] v_state_o;

  multicycle_controller dut (
    .clk(clk), .reset(rst), .op(op), .funct(funct), .zero(zero),
    .memready(memready), .pcen(pcen), .pcsrc(pcsrc), .iord(iord),
    .memread(memread), .memwrite(memwrite), .membyteread(membyteread),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .illegal(illegal), .state_o(state_o)
  );

  multicycle_controller #(
    .ALUCW(4), .EN_BNE(1'b0), .EN_JR(1'b0), .EN_LBU(1'b0)
  ) dut_v (
    .clk(clk), .reset(v_rst), .op(v_op), .funct(v_funct), .zero(v_zero),
    .memready(v_memready), .pcen(v_pcen), .pcsrc(v_pcsrc), .iord(v_iord),
    .memread(v_memread), .memwrite(v_memwrite), .membyteread(v_membyteread),
    .irwrite(v_irwrite), .regdst(v_regdst), .memtoreg(v_memtoreg),
    .regwrite(v_regwrite), .alusrca(v_alusrca), .alusrcb(v_alusrcb),
    .alucontrol(v_alucontrol), .illegal(v_illegal), .state_o(v_state_o)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Output snapshot of the default instance, field order:
  // pcen pcsrc iord memread memwrite membyteread irwrite regdst memtoreg
  // regwrite alusrca alusrcb illegal alucontrol
  function automatic logic [17:0] snap();
    return {pcen, pcsrc, iord, memread, memwrite, membyteread, irwrite,
            regdst, memtoreg, regwrite, alusrca, alusrcb, illegal, alucontrol};
  endfunction

  function automatic logic [17:0] sn(bit pe, bit [1:0] ps, bit io, bit mr,
                                     bit mw, bit mb, bit ir, bit rd, bit m2r,
                                     bit rw, bit sa, bit [1:0] sb, bit il,
                                     bit [2:0] alu);
    return {pe, ps, io, mr, mw, mb, ir, rd, m2r, rw, sa, sb, il, alu};
  endfunction

  // regwrite watchdog used around the reset-abort sequence
  logic mon_en = 1'b0;
  int   rw_seen = 0;
  always @(negedge clk) if (mon_en && regwrite === 1'b1) rw_seen++;

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          len;    // cycles, memready held high
    logic [19:0] st;     // state i in st[4*i +: 4]
    int          k;      // cycle index whose outputs are checked
    logic [17:0] exp;    // expected snapshot at cycle k
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(string nm, logic [5:0] o, logic [5:0] f,
                               logic z, int len, logic [19:0] st, int k,
                               logic [17:0] e);
    vec_t v;
    v.name = nm; v.op = o; v.funct = f; v.zero = z;
    v.len = len; v.st = st; v.k = k; v.exp = e;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // One cycle on the default instance: drive memready, expect a state.
  task automatic cyc(input logic mr, input logic [3:0] es, input string nm);
    logic [3:0] e;
    memready = mr;
    exp_q.push_back(es);
    @(negedge clk);
    e = exp_q.pop_front();
    chk(nm, state_o, e);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] e;
    op = v.op; funct = v.funct; zero = v.zero; memready = 1'b1;
    for (int i = 0; i < v.len; i++) exp_q.push_back(v.st[4*i +: 4]);
    for (int i = 0; i < v.len; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk({v.name, "_state"}, state_o, e);
      if (i == v.k) chk({v.name, "_outs"}, snap(), v.exp);
      @(posedge clk); #1;
    end
  endtask

  // Reduced instance: check state sequence and {illegal, alucontrol} at k.
  task automatic v_run(input string nm, input logic [5:0] o, input logic [5:0] f,
                       input int len, input logic [19:0] st, input int k,
                       input logic [4:0] exp_ia);
    logic [3:0] e;
    v_op = o; v_funct = f; v_zero = 1'b0; v_memready = 1'b1;
    for (int i = 0; i < len; i++) exp_q.push_back(st[4*i +: 4]);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk({nm, "_state"}, v_state_o, e);
      if (i == k) chk({nm, "_ill_alu"}, {v_illegal, v_alucontrol}, exp_ia);
      @(posedge clk); #1;
    end
    v_memready = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    int mw_cnt;
    logic [17:0] fetch_idle;

    // FETCH with memready low: only memread and the PC+4 ALU setup.
    fetch_idle = sn(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 3'b010);

    vecs.push_back(mkv("lw_fetch", 6'b100011, 6'd0, 0, 5, {4'd4,4'd3,4'd2,4'd1,4'd0}, 0,
      sn(1, 2'b00, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 0, 3'b010)));
    vecs.push_back(mkv("lw_decode", 6'b100011, 6'd0, 0, 5, {4'd4,4'd3,4'd2,4'd1,4'd0}, 1,
      sn(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 3'b010)));
    vecs.push_back(mkv("lw_memadr", 6'b100011, 6'd0, 0, 5, {4'd4,4'd3,4'd2,4'd1,4'd0}, 2,
      sn(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 3'b010)));
    vecs.push_back(mkv("lw_memrd", 6'b100011, 6'd0, 0, 5, {4'd4,4'd3,4'd2,4'd1,4'd0}, 3,
      sn(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b010)));
    vecs.push_back(mkv("lw_memwb", 6'b100011, 6'd0, 0, 5, {4'd4,4'd3,4'd2,4'd1,4'd0}, 4,
      sn(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 3'b010)));
    vecs.push_back(mkv("lbu_memrd", 6'b100100, 6'd0, 0, 5, {4'd4,4'd3,4'd2,4'd1,4'd0}, 3,
      sn(0, 2'b00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 3'b010)));
    vecs.push_back(mkv("lbu_memwb", 6'b100100, 6'd0, 0, 5, {4'd4,4'd3,4'd2,4'd1,4'd0}, 4,
      sn(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 3'b010)));
    vecs.push_back(mkv("sw_memwr", 6'b101011, 6'd0, 0, 4, {4'd0,4'd5,4'd2,4'd1,4'd0}, 3,
      sn(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b010)));
    vecs.push_back(mkv("r_add", 6'b000000, 6'b100000, 0, 4, {4'd0,4'd7,4'd6,4'd1,4'd0}, 2,
      sn(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 3'b010)));
    vecs.push_back(mkv("r_sub", 6'b000000, 6'b100010, 0, 4, {4'd0,4'd7,4'd6,4'd1,4'd0}, 2,
      sn(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 3'b110)));
    vecs.push_back(mkv("r_and", 6'b000000, 6'b100100, 0, 4, {4'd0,4'd7,4'd6,4'd1,4'd0}, 2,
      sn(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 3'b000)));
    vecs.push_back(mkv("r_or", 6'b000000, 6'b100101, 0, 4, {4'd0,4'd7,4'd6,4'd1,4'd0}, 2,
      sn(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 3'b001)));
    vecs.push_back(mkv("r_slt", 6'b000000, 6'b101010, 0, 4, {4'd0,4'd7,4'd6,4'd1,4'd0}, 2,
      sn(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 3'b111)));
    vecs.push_back(mkv("r_wb", 6'b000000, 6'b100010, 0, 4, {4'd0,4'd7,4'd6,4'd1,4'd0}, 3,
      sn(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 3'b010)));
    vecs.push_back(mkv("addi_ex", 6'b001000, 6'd0, 0, 4, {4'd0,4'd10,4'd9,4'd1,4'd0}, 2,
      sn(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 3'b010)));
    vecs.push_back(mkv("addi_wb", 6'b001000, 6'd0, 0, 4, {4'd0,4'd10,4'd9,4'd1,4'd0}, 3,
      sn(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 3'b010)));
    vecs.push_back(mkv("beq_taken", 6'b000100, 6'd0, 1, 3, {4'd0,4'd0,4'd0,4'd8,4'd1,4'd0} , 2,
      sn(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 3'b110)));
    vecs.push_back(mkv("beq_not", 6'b000100, 6'd0, 0, 3, {4'd0,4'd0,4'd8,4'd1,4'd0}, 2,
      sn(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 3'b110)));
    vecs.push_back(mkv("bne_zero1", 6'b000101, 6'd0, 1, 3, {4'd0,4'd0,4'd12,4'd1,4'd0}, 2,
      sn(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 3'b110)));
    vecs.push_back(mkv("bne_taken", 6'b000101, 6'd0, 0, 3, {4'd0,4'd0,4'd12,4'd1,4'd0}, 2,
      sn(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 3'b110)));
    vecs.push_back(mkv("j", 6'b000010, 6'd0, 0, 3, {4'd0,4'd0,4'd11,4'd1,4'd0}, 2,
      sn(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b010)));
    vecs.push_back(mkv("jr", 6'b000000, 6'b001000, 0, 3, {4'd0,4'd0,4'd13,4'd1,4'd0}, 2,
      sn(1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b010)));
    vecs.push_back(mkv("ill_op", 6'b111111, 6'd0, 0, 2, {4'd0,4'd0,4'd0,4'd1,4'd0}, 1,
      sn(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 3'b010)));
    vecs.push_back(mkv("ill_funct", 6'b000000, 6'b000001, 0, 2, {4'd0,4'd0,4'd0,4'd1,4'd0}, 1,
      sn(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 3'b010)));

    // reset state, with memready high so the forcing of pcen/irwrite shows
    rst = 1'b1; memready = 1'b1; zero = 1'b0; op = 6'b100011; funct = 6'd0;
    v_rst = 1'b1; v_memready = 1'b0; v_zero = 1'b0; v_op = 6'd0; v_funct = 6'd0;
    @(negedge clk);
    chk("reset_state", state_o, 4'd0);
    chk("reset_outs", snap(),
        sn(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 3'b010));
    @(posedge clk); #1;
    rst = 1'b0; v_rst = 1'b0;

    // FETCH stall: nothing committed until memready
    op = 6'b001000;
    cyc(1'b0, 4'd0, "fstall0");
    chk("fstall_outs", snap(), fetch_idle);
    cyc(1'b0, 4'd0, "fstall1");

    // table-driven vectors
    foreach (vecs[i]) run_vec(vecs[i]);

    // sw with three wait cycles in MEMWR
    op = 6'b101011; mw_cnt = 0;
    cyc(1'b1, 4'd0, "sws_f");
    cyc(1'b1, 4'd1, "sws_d");
    cyc(1'b1, 4'd2, "sws_a");
    for (int i = 0; i < 3; i++) begin
      memready = 1'b0;
      @(negedge clk);
      chk("sws_wait_state", state_o, 4'd5);
      if (memwrite) mw_cnt++;
      @(posedge clk); #1;
    end
    memready = 1'b1;
    @(negedge clk);
    chk("sws_done_state", state_o, 4'd5);
    if (memwrite) mw_cnt++;
    @(posedge clk); #1;
    memready = 1'b0;
    @(negedge clk);
    chk("sws_back_fetch", state_o, 4'd0);
    if (memwrite) mw_cnt++;
    chk("sws_memwrite_cycles", mw_cnt, 4);
    @(posedge clk); #1;

    // lw with two wait cycles in MEMRD
    op = 6'b100011;
    cyc(1'b1, 4'd0, "lws_f");
    cyc(1'b1, 4'd1, "lws_d");
    cyc(1'b1, 4'd2, "lws_a");
    cyc(1'b0, 4'd3, "lws_r0");
    cyc(1'b0, 4'd3, "lws_r1");
    cyc(1'b1, 4'd3, "lws_r2");
    cyc(1'b1, 4'd4, "lws_wb");
    cyc(1'b0, 4'd0, "lws_end");

    // reset asserted in MEMRD aborts the load
    cyc(1'b1, 4'd0, "rab_f");
    cyc(1'b1, 4'd1, "rab_d");
    cyc(1'b1, 4'd2, "rab_a");
    cyc(1'b0, 4'd3, "rab_r");
    mon_en = 1'b1;
    memready = 1'b1; rst = 1'b1;
    #1;
    chk("rab_async_state", state_o, 4'd0);
    chk("rab_forced", {pcen, irwrite, regwrite, memwrite, illegal}, 5'b00000);
    @(posedge clk); #1;
    chk("rab_held_state", state_o, 4'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rab_refetch", {state_o, irwrite, pcen}, {4'd0, 1'b1, 1'b1});
    @(posedge clk); #1;
    cyc(1'b1, 4'd1, "rab_d2");
    mon_en = 1'b0;
    chk("rab_no_regwrite", rw_seen, 0);
    cyc(1'b1, 4'd2, "rab_a2");
    cyc(1'b1, 4'd3, "rab_r2");
    cyc(1'b1, 4'd4, "rab_wb2");
    memready = 1'b0;

    // reduced instance: disabled features decode as illegal
    v_run("v_bne", 6'b000101, 6'd0, 2, {4'd0,4'd0,4'd0,4'd1,4'd0}, 1, 5'b10010);
    v_run("v_lbu", 6'b100100, 6'd0, 2, {4'd0,4'd0,4'd0,4'd1,4'd0}, 1, 5'b10010);
    v_run("v_jr", 6'b000000, 6'b001000, 2, {4'd0,4'd0,4'd0,4'd1,4'd0}, 1, 5'b10010);
    v_run("v_slt", 6'b000000, 6'b101010, 4, {4'd0,4'd7,4'd6,4'd1,4'd0}, 2, 5'b00111);
    v_run("v_beq", 6'b000100, 6'd0, 3, {4'd0,4'd0,4'd8,4'd1,4'd0}, 2, 5'b00110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM for the multicycle MIPS datapath, replacing the single-cycle decoder. It sequences fetch, decode, execute, memory and writeback over multiple cycles, and stalls on a memory ready handshake. It supports R-type, lw, lbu, sw, beq, bne, addi, j and jr. It is parametrised in ALU control width and in optional instruction support.

## Interface
- ALUCW, 3: alucontrol width, ≥3. Encodings are zero-extended into it.
- EN_BNE, 1: bne support. 0 makes opcode 000101 illegal.
- EN_JR, 1: jr support. 0 decodes R-type funct 001000 as illegal.
- EN_LBU, 1: lbu support. 0 makes opcode 100100 illegal.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; state←FETCH
- op  in  6  instr register opcode
- funct  in  6  instr register funct
- zero  in  1  ALU zero flag
- memready  in  1  memory completes access this cycle
- pcen  out  1  PC register enable
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs (jr)
- iord  out  1  memory address from ALUOut
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- membyteread  out  1  byte read, zero-extend (lbu)
- irwrite  out  1  instruction register load
- regdst  out  1  write rd (else rt)
- memtoreg  out  1  writeback from data register
- regwrite  out  1  register file write
- alusrca  out  1  A operand: 0 PC, 1 rs
- alusrcb  out  2  B operand: 00 rt, 01 const 4, 10 signimm, 11 signimm<<2
- alucontrol  out  ALUCW  ALU operation
- illegal  out  1  one-cycle pulse on an unsupported instruction
- state_o  out  4  current state, for debug

## Operation
- Opcodes:
  - R 000000, lw 100011, lbu 100100, sw 101011
  - beq 000100, bne 000101, addi 001000, j 000010
  - jr is R-type with funct 001000.
- States and transitions:
  - FETCH→DECODE on memready, else hold.
  - DECODE→MEMADR for lw, lbu, sw.
  - DECODE→RTYPEEX for R-type, or JREX when funct is jr.
  - DECODE→BEQEX, BNEEX, ADDIEX or JEX by opcode.
  - DECODE→FETCH for an illegal instruction.
  - MEMADR→MEMRD for lw/lbu, MEMWR for sw.
  - MEMRD→MEMWB on memready, else hold.
  - MEMWR→FETCH on memready, else hold.
  - RTYPEEX→RTYPEWB→FETCH. ADDIEX→ADDIWB→FETCH.
  - BEQEX, BNEEX, JEX, JREX→FETCH.
- Outputs per state (unlisted outputs are 0, alucontrol defaults to add):
  - FETCH: memread=1, alusrcb=01, add, pcsrc=00. irwrite=memready. PC write = memready.
  - DECODE: alusrcb=11, add. Computes the branch target into ALUOut.
  - MEMADR: alusrca=1, alusrcb=10, add.
  - MEMRD: memread=1, iord=1, membyteread=1 when op is lbu.
  - MEMWB: regwrite=1, memtoreg=1.
  - MEMWR: memwrite=1, iord=1.
  - RTYPEEX: alusrca=1, alucontrol from funct.
  - RTYPEWB: regwrite=1, regdst=1.
  - BEQEX: alusrca=1, sub, pcsrc=01. Branch taken when zero=1.
  - BNEEX: same as BEQEX, but taken when zero=0.
  - ADDIEX: alusrca=1, alusrcb=10, add.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, PC write.
  - JREX: pcsrc=11, PC write.
- pcen = pcwrite | (beq_state & zero) | (bne_state & ~zero).
- alucontrol encodings:
  - add 010, sub 110, and 000, or 001, slt 111.
  - Funct 100000, 100010, 100100, 100101, 101010 map to these in order.
  - Any other funct gives add, with illegal asserted in DECODE.
- illegal is asserted combinationally in DECODE only.

## Timing
- Cycle counts with memready held high:
  - lw/lbu 5, sw 4, R-type 4, addi 4.
  - beq, bne, j, jr 3. Illegal instruction 2.
- Each cycle with memready=0 in FETCH, MEMRD or MEMWR adds one stall cycle.
  - Outputs stay stable during the stall.
  - irwrite, pcen and memwrite completion happen only in the memready cycle.
  - memwrite stays high through the MEMWR wait, until memready.
- While reset is high:
  - state=FETCH.
  - pcen, irwrite, regwrite and memwrite are forced to 0.
  - Other outputs take their FETCH values.
  - illegal=0.
- Reset asserted mid-instruction aborts the instruction immediately.
  - No further register or memory write occurs.
  - First fetch happens on the first edge after deassertion with memready=1.
- op and funct are sampled only in DECODE and later states. The instruction register holds them stable after FETCH.

## Structure
- Package mips_ctrl_pkg holds:
  - state enum (4 bits; FETCH=0, explicit encodings);
  - opcode and funct localparams;
  - ALU operation constants.
- Sub-module mc_aludec: combinational, with aluop (2 bits) and funct in, alucontrol[ALUCW-1:0] and bad_funct out.
- The FSM register, next-state logic and output decode live in the top module.

## Test plan
- lw, memready=1: states 0→1→2→3→4→0 in 5 cycles. MEMWB has regwrite=1, memtoreg=1.
- sw, memready low for 3 cycles in MEMWR: memwrite=1 for 4 cycles. Return to FETCH on the cycle after memready.
- beq/bne:
  - beq with zero=1 gives pcen=1, pcsrc=01.
  - bne with zero=1 gives pcen=0.
  - With EN_BNE=0, op 000101 pulses illegal in DECODE, then FETCH.
- R-type ALU and jr:
  - R-type funct 101010 gives alucontrol=111 in RTYPEEX; with ALUCW=4 it gives 0111.
  - jr gives JREX with pcsrc=11, pcen=1.
- Reset asserted in MEMRD: state=0 asynchronously. No regwrite pulse. Fetch resumes after release.
- lbu: membyteread=1 only in MEMRD. With EN_LBU=0, illegal is pulsed.
